gesture_score_accumulator: RTL and testbench

Scoring stage that consumes the per-class signed weights of the four gesture weight ROMs and the voxel-bin event counts. It sweeps one shared cell address across all NUM_CELLS voxel cells. Each cycle it accumulates count × weight into one signed score per class, then picks the winning class with a serial argmax. It sits between the voxel-bin buffer / weight ROM bank, which it addresses, and the gesture output / UART reporting logic, which consumes `result_*`.

---
 rtl/gesture_score_accumulator_if.sv | 34 +++
 rtl/gesture_score_accumulator.sv | 129 ++++++++++++
 tb/tb_gesture_score_accumulator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/gesture_score_accumulator_if.sv
// Handshake/bus bundle for gesture_score_accumulator.
//   slave  : the accumulator (drives cell_addr, busy and result_*).
//   master : the sequencer/memories (drives start, voxel_count, weight_in).
// voxel_count and weight_in are registered reads of cell_addr (1-cycle latency).
interface gesture_score_accumulator_if #(
    parameter int NUM_CELLS   = 1024,
    parameter int NUM_CLASSES = 4,
    parameter int WEIGHT_BITS = 8,
    parameter int COUNT_BITS  = 4,
    parameter int SCORE_BITS  = 24
);
    localparam int ADDR_W = $clog2(NUM_CELLS);
    localparam int CLS_W  = $clog2(NUM_CLASSES);

    logic                               start;
    logic [ADDR_W-1:0]                  cell_addr;
    logic [COUNT_BITS-1:0]              voxel_count;
    logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_in;
    logic                               busy;
    logic                               result_valid;
    logic [CLS_W-1:0]                   result_class;
    logic [SCORE_BITS-1:0]              result_score;
    logic                               result_confident;

    modport slave (
        input  start, voxel_count, weight_in,
        output cell_addr, busy, result_valid, result_class, result_score, result_confident
    );

    modport master (
        output start, voxel_count, weight_in,
        input  cell_addr, busy, result_valid, result_class, result_score, result_confident
    );
endinterface

// File: rtl/gesture_score_accumulator.sv
// Gesture scoring stage: sweeps one shared cell address over all voxel cells,
// accumulates count x weight per class, then runs a serial argmax.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - gesture_score_accumulator_if.slave:
//          start in; cell_addr out; voxel_count/weight_in in (1-cycle read latency);
//          busy, result_valid (pulse), result_class, result_score, result_confident out.
module gesture_score_accumulator #(
    parameter int NUM_CELLS   = 1024,
    parameter int NUM_CLASSES = 4,
    parameter int WEIGHT_BITS = 8,
    parameter int COUNT_BITS  = 4,
    parameter int SCORE_BITS  = 24,
    parameter int MIN_SCORE   = 1
) (
    input  logic clk,
    input  logic rst,
    gesture_score_accumulator_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_CELLS);
    localparam int CLS_W  = $clog2(NUM_CLASSES);
    localparam int PROD_W = COUNT_BITS + WEIGHT_BITS + 1;

    localparam logic [ADDR_W-1:0]            LAST_ADDR = ADDR_W'(NUM_CELLS - 1);
    localparam logic [CLS_W-1:0]             LAST_CLS  = CLS_W'(NUM_CLASSES - 1);
    localparam logic signed [SCORE_BITS-1:0] MIN_S     = SCORE_BITS'(MIN_SCORE);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, ARGMAX} state_t;

    state_t                        state;
    logic                          rd_vld;   // tags memory data returning this cycle
    logic [CLS_W-1:0]              arg_idx;
    logic signed [SCORE_BITS-1:0]  acc [NUM_CLASSES];
    logic signed [SCORE_BITS-1:0]  best_score;
    logic [CLS_W-1:0]              best_class;

    // Per-class product; count is zero-extended so it stays non-negative.
    logic signed [PROD_W-1:0] prod [NUM_CLASSES];

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_mul
        logic signed [PROD_W-1:0] cnt_ext;
        logic signed [PROD_W-1:0] w_ext;
        logic [WEIGHT_BITS-1:0]   w;
        assign w       = bus.weight_in[k*WEIGHT_BITS +: WEIGHT_BITS];
        assign cnt_ext = $signed({{(WEIGHT_BITS+1){1'b0}}, bus.voxel_count});
        assign w_ext   = $signed({{(COUNT_BITS+1){w[WEIGHT_BITS-1]}}, w});
        assign prod[k] = cnt_ext * w_ext;
    end

    // Argmax candidate: strict greater-than keeps the lower index on ties.
    logic signed [SCORE_BITS-1:0] cand_score;
    logic [CLS_W-1:0]             cand_class;

    always_comb begin
        cand_score = best_score;
        cand_class = best_class;
        if (acc[arg_idx] > best_score) begin
            cand_score = acc[arg_idx];
            cand_class = arg_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            rd_vld               <= 1'b0;
            arg_idx              <= '0;
            best_score           <= '0;
            best_class           <= '0;
            bus.cell_addr        <= '0;
            bus.busy             <= 1'b0;
            bus.result_valid     <= 1'b0;
            bus.result_class     <= '0;
            bus.result_score     <= '0;
            bus.result_confident <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            rd_vld           <= (state == SWEEP);

            if (rd_vld) begin
                for (int k = 0; k < NUM_CLASSES; k++)
                    acc[k] <= acc[k] + {{(SCORE_BITS-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= '0;
                        bus.cell_addr <= '0;
                        bus.busy      <= 1'b1;
                        state         <= SWEEP;
                    end
                end
                SWEEP: begin
                    // Address holds at the last cell; no wrap within a sweep.
                    if (bus.cell_addr == LAST_ADDR) state <= DRAIN;
                    else                            bus.cell_addr <= bus.cell_addr + 1'b1;
                end
                DRAIN: begin
                    // Last returning data is accumulated on this edge.
                    arg_idx <= '0;
                    state   <= ARGMAX;
                end
                ARGMAX: begin
                    if (arg_idx == '0) begin
                        best_score <= acc[0];
                        best_class <= '0;
                    end else begin
                        best_score <= cand_score;
                        best_class <= cand_class;
                    end
                    if (arg_idx == LAST_CLS) begin
                        bus.result_valid     <= 1'b1;
                        bus.result_class     <= cand_class;
                        bus.result_score     <= cand_score;
                        bus.result_confident <= (cand_score >= MIN_S);
                        bus.busy             <= 1'b0;
                        state                <= IDLE;
                    end else begin
                        arg_idx <= arg_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gesture_score_accumulator.sv
// Self-checking bench for gesture_score_accumulator: directed vector table,
// randomized back-to-back sweeps against a behavioural score model, and a
// mid-sweep reset sequence.
module tb_gesture_score_accumulator;
    localparam int NC = 1024, NK = 4, WB = 8, CB = 4, SB = 24;
    localparam int LAT = NC + 1 + NK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gesture_score_accumulator_if #(.NUM_CELLS(NC), .NUM_CLASSES(NK), .WEIGHT_BITS(WB),
                                   .COUNT_BITS(CB), .SCORE_BITS(SB)) bus ();

    gesture_score_accumulator #(.NUM_CELLS(NC), .NUM_CLASSES(NK), .WEIGHT_BITS(WB),
                                .COUNT_BITS(CB), .SCORE_BITS(SB), .MIN_SCORE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Voxel buffer and weight ROM bank: registered reads of cell_addr.
    logic [CB-1:0]        count_mem [NC];
    logic signed [WB-1:0] w_mem     [NC][NK];

    always @(posedge clk) begin
        bus.voxel_count <= count_mem[bus.cell_addr];
        for (int k = 0; k < NK; k++)
            bus.weight_in[k*WB +: WB] <= w_mem[bus.cell_addr][k];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: dot product per class, then first maximum wins.
    task automatic model(output int cls, output longint score);
        longint s [NK];
        for (int k = 0; k < NK; k++) s[k] = 0;
        for (int a = 0; a < NC; a++)
            for (int k = 0; k < NK; k++)
                s[k] += longint'(count_mem[a]) * longint'(w_mem[a][k]);
        cls = 0;
        for (int k = 1; k < NK; k++) if (s[k] > s[cls]) cls = k;
        score = s[cls];
    endtask

    task automatic set_w(input int a, input int w0, input int w1, input int w2, input int w3);
        w_mem[a][0] = WB'(w0); w_mem[a][1] = WB'(w1);
        w_mem[a][2] = WB'(w2); w_mem[a][3] = WB'(w3);
    endtask

    // Random background weights; counts zero except where the pattern sets them.
    task automatic load(input int pat);
        for (int a = 0; a < NC; a++) begin
            count_mem[a] = '0;
            for (int k = 0; k < NK; k++) w_mem[a][k] = WB'($urandom_range(0, 255));
        end
        case (pat)
            1: begin count_mem[776] = 1; set_w(776, 8, -8, -1, 1); end
            2: begin
                count_mem[240] = 15; set_w(240, 8, -8, 0, 0);
                count_mem[768] = 15; set_w(768, 8, -8, 0, 0);
            end
            3: begin
                count_mem[0]    = 15; set_w(0,    -8, 8, 0, 0);
                count_mem[1008] = 15; set_w(1008, -8, 8, 0, 0);
            end
            4: begin count_mem[10] = 1; set_w(10, 5, 0, 0, 5); end
            5: begin count_mem[10] = 1; set_w(10, 5, 0, 0, 6); end
            6: for (int a = 0; a < NC; a++) begin
                count_mem[a] = 15; set_w(a, -128, -128, -128, -128);
            end
            7: for (int a = 0; a < NC; a++) begin
                count_mem[a] = CB'($urandom_range(0, 15));
                for (int k = 0; k < NK; k++) w_mem[a][k] = WB'($urandom_range(0, 255));
            end
            default: ;
        endcase
    endtask

    // Entered and left #1 after a rising edge. Returns on the result_valid cycle.
    task automatic run_sweep(input string tag, input bit mid_start, output int lat);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, " busy_rise"}, bus.busy, 1);
        lat = 0;
        while (!bus.result_valid && lat < 2 * LAT) begin
            if (mid_start) bus.start = (lat == 300);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " busy_fall"}, bus.busy, 0);
    endtask

    typedef struct {
        string  name;
        int     pat;
        bit     mid_start;
        int     cls;
        longint score;
        bit     conf;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, mcls;
        longint msc;

        vecs[0] = '{"zero",      0, 1'b0, 0, 0,        1'b0};
        vecs[1] = '{"single",    1, 1'b0, 0, 8,        1'b1};
        vecs[2] = '{"up240",     2, 1'b0, 0, 240,      1'b1};
        vecs[3] = '{"down240",   3, 1'b0, 1, 240,      1'b1};
        vecs[4] = '{"tie",       4, 1'b0, 0, 5,        1'b1};
        vecs[5] = '{"right_win", 5, 1'b0, 3, 6,        1'b1};
        vecs[6] = '{"max_neg",   6, 1'b1, 0, -1966080, 1'b0};

        bus.start = 1'b0;
        load(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst cell_addr", bus.cell_addr, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst result_valid", bus.result_valid, 0);
        chk("rst result_class", bus.result_class, 0);
        chk("rst result_score", bus.result_score, 0);
        chk("rst result_confident", bus.result_confident, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            load(vecs[i].pat);
            run_sweep(vecs[i].name, vecs[i].mid_start, lat);
            chk({vecs[i].name, " class"}, bus.result_class, vecs[i].cls);
            chk({vecs[i].name, " score"}, longint'($signed(bus.result_score)), vecs[i].score);
            chk({vecs[i].name, " conf"}, bus.result_confident, vecs[i].conf);
            @(posedge clk); #1;
            chk({vecs[i].name, " pulse_1cyc"}, bus.result_valid, 0);
            chk({vecs[i].name, " hold_class"}, bus.result_class, vecs[i].cls);
            chk({vecs[i].name, " hold_score"}, longint'($signed(bus.result_score)), vecs[i].score);
            chk({vecs[i].name, " cell_addr_hold"}, bus.cell_addr, NC - 1);
        end

        // Random sweeps, each started in the previous result cycle.
        for (int r = 0; r < 4; r++) begin
            load(7);
            model(mcls, msc);
            run_sweep("rand", 1'b0, lat);
            chk("rand class", bus.result_class, mcls);
            chk("rand score", longint'($signed(bus.result_score)), msc);
            chk("rand conf", bus.result_confident, msc >= 1);
        end
        @(posedge clk); #1;

        // Reset in the middle of a sweep: outputs clear at once, no result.
        load(1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst cell_addr", bus.cell_addr, 0);
        chk("mrst busy", bus.busy, 0);
        chk("mrst result_valid", bus.result_valid, 0);
        chk("mrst result_class", bus.result_class, 0);
        chk("mrst result_score", bus.result_score, 0);
        chk("mrst result_confident", bus.result_confident, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < LAT + 20; c++) begin
                @(posedge clk); #1;
                if (bus.result_valid) seen++;
            end
            chk("mrst no_result", seen, 0);
        end
        run_sweep("post_rst", 1'b0, lat);
        chk("post_rst class", bus.result_class, 0);
        chk("post_rst score", longint'($signed(bus.result_score)), 8);
        chk("post_rst conf", bus.result_confident, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
